// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Imported by the arbiter top and its scoreboard.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        MEM_PRI = 1'b0,
        ALU_PRI = 1'b1
    } pri_e;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap for the register file.
// Newer producer wins when a bit is set and cleared together.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW = regfile_pkg::ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic [AW-1:0] chk_s1_i,
    input  logic [AW-1:0] chk_s2_i,
    output logic          hazard_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first, then set, so a same-bit collision stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != AW'(REG_ZERO))) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Bitmap register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign hazard_o = busy_q[chk_s1_i] | busy_q[chk_s2_i];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants ALU or load path onto the single
// register-file write port, with starvation relief for the ALU.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W       = regfile_pkg::ADDR_W,
    parameter int DATA_W       = regfile_pkg::DATA_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] chk_addr_s1,
    input  logic [ADDR_W-1:0] chk_addr_s2,
    output logic              hazard,
    output logic [31:0]       busy,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_address_d,
    output logic [DATA_W-1:0] rf_data_dval
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    pri_e              state_q;
    pri_e              state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              xfer_alu;
    logic              xfer_mem;
    logic              xfer;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    // Ready generation from the current priority; held off in reset.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                ALU_PRI: begin
                    alu_ready = alu_valid;
                    mem_ready = mem_valid && !alu_valid;
                end
                default: begin
                    mem_ready = mem_valid;
                    alu_ready = alu_valid && !mem_valid;
                end
            endcase
        end
    end

    assign xfer_alu = alu_valid && alu_ready;
    assign xfer_mem = mem_valid && mem_ready;
    assign xfer     = xfer_alu || xfer_mem;
    assign gnt_addr = xfer_alu ? alu_addr : mem_addr;
    assign gnt_data = xfer_alu ? alu_data : mem_data;

    // Starvation counting; ALU priority lasts a single cycle.
    always_comb begin
        state_d = MEM_PRI;
        cnt_d   = cnt_q;
        if (state_q == ALU_PRI) begin
            cnt_d = '0;
        end else if (xfer_alu) begin
            cnt_d = '0;
        end else if (alu_valid) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LIMIT) begin
                state_d = ALU_PRI;
            end
        end
    end

    // Priority state and starvation counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= MEM_PRI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered write stage; $0 is accepted but never written.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= xfer && (gnt_addr != ADDR_W'(REG_ZERO));
            if (xfer) begin
                addr_q <= gnt_addr;
                data_q <= gnt_data;
            end
        end
    end

    assign rf_write_enable = we_q;
    assign rf_address_d    = addr_q;
    assign rf_data_dval    = data_q;

    wb_scoreboard #(
        .AW(ADDR_W)
    ) u_sb (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .set_en_i  (issue_valid),
        .set_addr_i(issue_addr),
        .clr_en_i  (we_q),
        .clr_addr_i(addr_q),
        .chk_s1_i  (chk_addr_s1),
        .chk_s2_i  (chk_addr_s2),
        .hazard_o  (hazard),
        .busy_o    (busy)
    );

endmodule
